// File: rtl/addr_queue_ctrl.sv
// Ready/valid FIFO controller in front of an external 1R1W synchronous-read SRAM.
// Optional flush input is enabled by defining ADDR_QUEUE_FLUSH_EN.
module addr_queue_ctrl #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
`ifdef ADDR_QUEUE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [WIDTH-1:0]  enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [WIDTH-1:0]  deq_bits,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic              mem_W0_en,
  output logic [WIDTH-1:0]  mem_W0_data,
  output logic [ADDR_W-1:0] mem_R0_addr,
  output logic              mem_R0_en,
  input  logic [WIDTH-1:0]  mem_R0_data
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  unread;
  logic              rd_pend;
  logic              hold_valid;
  logic [WIDTH-1:0]  hold_data;

  logic flush_c;
  logic head_valid;
  logic enq_fire;
  logic deq_fire;
  logic rd_issue;

`ifdef ADDR_QUEUE_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Handshakes and SRAM port control; flush and reset block both sides.
  always_comb begin
    head_valid = rd_pend | hold_valid;
    enq_ready  = !reset && !flush_c && (count_q != CNT_W'(DEPTH));
    enq_fire   = enq_valid && enq_ready;
    deq_valid  = head_valid && !reset && !flush_c;
    deq_fire   = deq_valid && deq_ready;
    rd_issue   = !reset && !flush_c && (unread != '0) && (!head_valid || deq_fire);
    deq_bits   = hold_valid ? hold_data : mem_R0_data;
  end

  assign count       = count_q;
  assign mem_W0_en   = enq_fire;
  assign mem_W0_addr = wr_ptr;
  assign mem_W0_data = enq_bits;
  assign mem_R0_en   = rd_issue;
  assign mem_R0_addr = rd_ptr;

  // Slots are released on deq only, so a write never targets an address still in flight on R0.
  always_ff @(posedge clock) begin
    if (reset || flush_c) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      unread     <= '0;
      rd_pend    <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_W'(1);
      unread  <= unread + CNT_W'(enq_fire) - CNT_W'(rd_issue);
      count_q <= count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
      rd_pend <= rd_issue;
      // Park read data that arrives while the consumer stalls.
      if (deq_fire) begin
        hold_valid <= 1'b0;
      end else if (rd_pend) begin
        hold_valid <= 1'b1;
        hold_data  <= mem_R0_data;
      end
    end
  end

endmodule
